mem_stage_reg: RTL and testbench
================================

Name: mem_stage_reg

Overview:
- Memory-access pipeline stage (MS) directly downstream of the execute stage; consumes es2ms_bus, feeds the write-back stage over ms2ws_bus.
- Receives synchronous data-SRAM read data one cycle after the execute stage issued the request.
- Aligns and sign/zero-extends load data, selects the final register write value, and exports a forwarding zip to decode.
- Holds captured load data across write-back back-pressure, because the SRAM output is not stable while the execute stage re-issues requests.

Parameters:
- None; widths fixed by pipeline bus contract. Localparams: ES2MS_W=76, MS2WS_W=70, MS_ZIP_W=38.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- ms_allowin  out  1  stage can accept a new instruction this cycle
- es2ms_valid  in  1  execute stage presents a valid instruction
- es2ms_bus  in  76  {res_from_mem[75], mem_re_s[74], mem_re[73:70], rf_we[69], rf_waddr[68:64], alu_result[63:32], pc[31:0]}
- data_sram_rdata  in  32  SRAM read word; valid only in first cycle a load occupies MS
- ms2ws_valid  out  1  valid instruction offered to write-back
- ms2ws_bus  out  70  {rf_we[69], rf_waddr[68:64], final_result[63:32], pc[31:0]}
- ws_allowin  in  1  write-back can accept
- ms_rf_zip  out  38  {rf_we & ms_valid, rf_waddr, final_result}; forwarding/hazard info for decode

Behaviour:
- Reset (resetn=0 at clk edge): ms_valid=0; all bus registers=0; hold_valid=0; hold_data=0. Consequently ms2ws_valid=0, ms_rf_zip=0, ms_allowin=1.
- ms_ready_go=1 (single-cycle stage).
- ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin).
- ms2ws_valid = ms_valid & ms_ready_go.
- ms_valid: if ms_allowin, load es2ms_valid at clk edge; otherwise hold.
- Bus registers load only when es2ms_valid & ms_allowin; otherwise hold (no bubble clears data).
- first_cycle flag: set when a new instruction is latched, cleared on the next edge.
- Load-data hold register:
  - If ms_valid & first_cycle & ~ws_allowin, capture data_sram_rdata into hold_data and set hold_valid.
  - Clear hold_valid when a new instruction is latched or reset.
- Raw word selection: raw = hold_valid ? hold_data : data_sram_rdata.
- Alignment: shifted = raw >> (8*alu_result[1:0]).
- Extraction by mem_re:
  - 4'h1: byte = shifted[7:0]
  - 4'h3: half = shifted[15:0]; alu_result[1] selects the half, alu_result[0] ignored
  - 4'hf: whole word
  - Any other code is treated as no load.
- Extension: mem_re_s=1 sign-extends, 0 zero-extends; has no effect for word loads.
- final_result = res_from_mem ? extended load value : alu_result.
- ms_rf_zip is combinational from current registers, so decode sees a stalled load's value every stall cycle.
- Simultaneous transfer in and out when ms_valid & ws_allowin & es2ms_valid: the new instruction replaces the old in one edge; no lost or duplicated instruction.
- Reset asserted mid-stall: discards the held instruction and hold data.

Decomposition:
- Shared package (pipeline_pkg):
  - MEM_RE_B=4'h1, MEM_RE_H=4'h3, MEM_RE_W=4'hf
  - bus width constants ES2MS_W, MS2WS_W, MS_ZIP_W
  - es2ms field offsets
- One sub-module, load_align (combinational):
  - inputs: raw[31:0], addr_lo[1:0], mem_re[3:0], mem_re_s
  - output: value[31:0]
  - reused by future unaligned-access exception logic.

Test Plan:
- Signed byte load:
  - Stimulus: bus res_from_mem=1, mem_re_s=1, mem_re=4'h1, alu_result=0x00001003, rf_waddr=5; next cycle rdata=0x80112233; ws_allowin=1.
  - Required: ms2ws final_result=0xFFFFFF80, rf_we=1, waddr=5.
- Unsigned half load:
  - Stimulus: mem_re=4'h3, mem_re_s=0, alu_result=0x00002002, rdata=0x80017FFF.
  - Required: final_result=0x00008001. Same with mem_re_s=1 gives 0xFFFF8001.
- Stalled load:
  - Stimulus: word load, rdata=0x12345678 in first cycle, ws_allowin=0 for 3 cycles while rdata changes to 0xDEADBEEF.
  - Required: ms_rf_zip and ms2ws_bus final_result stay 0x12345678 throughout; ms_allowin=0 while stalled; one transfer on release.
- Non-load pass-through and back-to-back:
  - Stimulus: three ALU ops (alu_result 0xA, 0xB, 0xC) on consecutive cycles with ws_allowin=1.
  - Required: ms2ws_valid high three consecutive cycles with results 0xA, 0xB, 0xC in order.
- Bubble and zip gating:
  - Stimulus: es2ms_valid=0 after an instruction with rf_we=1 leaves.
  - Required: ms2ws_valid=0; ms_rf_zip[37]=0 while bus registers retain old data.
- Reset mid-stall:
  - Stimulus: resetn=0 for one edge while a load is held with ws_allowin=0.
  - Required: next cycle ms_valid=0, ms_allowin=1, ms_rf_zip=0, hold_valid=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
//   Shared constants for the pipeline stage buses:
//   - bus widths for execute->memory, memory->write-back and the memory-stage
//     forwarding zip
//   - load-width encodings carried in mem_re
//   - bit offsets of the fields packed into es2ms_bus
// -----------------------------------------------------------------------------
package pipeline_pkg;

    localparam int ES2MS_W  = 76;
    localparam int MS2WS_W  = 70;
    localparam int MS_ZIP_W = 38;

    // mem_re load-width codes (byte-enable style)
    localparam logic [3:0] MEM_RE_B = 4'h1;
    localparam logic [3:0] MEM_RE_H = 4'h3;
    localparam logic [3:0] MEM_RE_W = 4'hf;

    // es2ms_bus field offsets
    localparam int ES_PC_LSB        = 0;
    localparam int ES_ALU_LSB       = 32;
    localparam int ES_WADDR_LSB     = 64;
    localparam int ES_RF_WE         = 69;
    localparam int ES_MEM_RE_LSB    = 70;
    localparam int ES_MEM_RE_S      = 74;
    localparam int ES_RES_FROM_MEM  = 75;

endpackage

// File: rtl/load_align.sv
// -----------------------------------------------------------------------------
// load_align
//   Combinational load-data aligner: picks the addressed byte/half/word out
//   of a 32-bit read word and sign- or zero-extends it.
// Ports:
//   raw      in  32  read word from memory (or the held copy)
//   addr_lo  in  2   low address bits of the access
//   mem_re   in  4   load width code (byte / half / word, anything else = none)
//   mem_re_s in  1   1 = sign-extend, 0 = zero-extend (ignored for words)
//   value    out 32  aligned, extended load value (0 for non-load codes)
// -----------------------------------------------------------------------------
module load_align
    import pipeline_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  addr_lo,
    input  logic [3:0]  mem_re,
    input  logic        mem_re_s,
    output logic [31:0] value
);

    logic [31:0] shifted;
    logic [15:0] half;

    always_comb begin
        shifted = raw >> {addr_lo, 3'b000};
        // Halfword select uses only addr_lo[1]; an odd byte offset is ignored.
        half    = addr_lo[1] ? raw[31:16] : raw[15:0];
        value   = 32'h0;
        case (mem_re)
            MEM_RE_B: value = {{24{mem_re_s & shifted[7]}}, shifted[7:0]};
            MEM_RE_H: value = {{16{mem_re_s & half[15]}}, half};
            MEM_RE_W: value = shifted;
            default:  value = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_stage_reg.sv
// -----------------------------------------------------------------------------
// mem_stage_reg
//   Memory-access pipeline stage. Latches the execute-stage bus, aligns and
//   extends the synchronous SRAM read data, selects the register write value
//   and hands it to write-back. Because the SRAM output is only valid in the
//   first cycle a load sits here, that word is captured into a hold register
//   if write-back stalls us during that cycle.
// Ports:
//   clk              in  1   clock
//   resetn           in  1   synchronous active-low reset
//   ms_allowin       out 1   stage can accept a new instruction
//   es2ms_valid      in  1   execute stage offers a valid instruction
//   es2ms_bus        in  76  {res_from_mem, mem_re_s, mem_re, rf_we, rf_waddr,
//                             alu_result, pc}
//   data_sram_rdata  in  32  SRAM read word
//   ms2ws_valid      out 1   valid instruction offered to write-back
//   ms2ws_bus        out 70  {rf_we, rf_waddr, final_result, pc}
//   ws_allowin       in  1   write-back can accept
//   ms_rf_zip        out 38  {rf_we & ms_valid, rf_waddr, final_result}
// -----------------------------------------------------------------------------
module mem_stage_reg
    import pipeline_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    output logic                 ms_allowin,
    input  logic                 es2ms_valid,
    input  logic [ES2MS_W-1:0]   es2ms_bus,
    input  logic [31:0]          data_sram_rdata,
    output logic                 ms2ws_valid,
    output logic [MS2WS_W-1:0]   ms2ws_bus,
    input  logic                 ws_allowin,
    output logic [MS_ZIP_W-1:0]  ms_rf_zip
);

    logic                ms_valid_q,    ms_valid_d;
    logic [ES2MS_W-1:0]  es_bus_q,      es_bus_d;
    logic                first_cycle_q, first_cycle_d;
    logic                hold_valid_q,  hold_valid_d;
    logic [31:0]         hold_data_q,   hold_data_d;

    logic        ms_ready_go;
    logic        accept;

    // Decoded fields of the latched bus
    logic        res_from_mem;
    logic        mem_re_s;
    logic [3:0]  mem_re;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] alu_result;
    logic [31:0] pc;

    logic [31:0] raw_word;
    logic [31:0] load_value;
    logic [31:0] final_result;

    assign ms_ready_go = 1'b1;
    assign ms_allowin  = ~ms_valid_q | (ms_ready_go & ws_allowin);
    assign ms2ws_valid = ms_valid_q & ms_ready_go;
    assign accept      = es2ms_valid & ms_allowin;

    assign res_from_mem = es_bus_q[ES_RES_FROM_MEM];
    assign mem_re_s     = es_bus_q[ES_MEM_RE_S];
    assign mem_re       = es_bus_q[ES_MEM_RE_LSB +: 4];
    assign rf_we        = es_bus_q[ES_RF_WE];
    assign rf_waddr     = es_bus_q[ES_WADDR_LSB +: 5];
    assign alu_result   = es_bus_q[ES_ALU_LSB +: 32];
    assign pc           = es_bus_q[ES_PC_LSB +: 32];

    // After the first cycle of a stalled load the SRAM port belongs to the
    // execute stage again, so the captured copy must be used instead.
    assign raw_word = hold_valid_q ? hold_data_q : data_sram_rdata;

    load_align u_load_align (
        .raw      (raw_word),
        .addr_lo  (alu_result[1:0]),
        .mem_re   (mem_re),
        .mem_re_s (mem_re_s),
        .value    (load_value)
    );

    assign final_result = res_from_mem ? load_value : alu_result;

    assign ms2ws_bus = {rf_we, rf_waddr, final_result, pc};
    assign ms_rf_zip = {rf_we & ms_valid_q, rf_waddr, final_result};

    always_comb begin
        ms_valid_d    = ms_allowin ? es2ms_valid : ms_valid_q;
        // A bubble leaves the old bus contents in place; only ms_valid drops.
        es_bus_d      = accept ? es2ms_bus : es_bus_q;
        first_cycle_d = accept;
        hold_valid_d  = hold_valid_q;
        hold_data_d   = hold_data_q;
        if (accept) begin
            hold_valid_d = 1'b0;
        end else if (ms_valid_q && first_cycle_q && !ws_allowin) begin
            hold_valid_d = 1'b1;
            hold_data_d  = data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ms_valid_q    <= 1'b0;
            es_bus_q      <= '0;
            first_cycle_q <= 1'b0;
            hold_valid_q  <= 1'b0;
            hold_data_q   <= 32'h0;
        end else begin
            ms_valid_q    <= ms_valid_d;
            es_bus_q      <= es_bus_d;
            first_cycle_q <= first_cycle_d;
            hold_valid_q  <= hold_valid_d;
            hold_data_q   <= hold_data_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_reg.sv
module tb_mem_stage_reg;

    logic        clk;
    logic        resetn;
    logic        ms_allowin;
    logic        es2ms_valid;
    logic [75:0] es2ms_bus;
    logic [31:0] data_sram_rdata;
    logic        ms2ws_valid;
    logic [69:0] ms2ws_bus;
    logic        ws_allowin;
    logic [37:0] ms_rf_zip;

    int checks;
    int errors;

    mem_stage_reg dut (
        .clk             (clk),
        .resetn          (resetn),
        .ms_allowin      (ms_allowin),
        .es2ms_valid     (es2ms_valid),
        .es2ms_bus       (es2ms_bus),
        .data_sram_rdata (data_sram_rdata),
        .ms2ws_valid     (ms2ws_valid),
        .ms2ws_bus       (ms2ws_bus),
        .ws_allowin      (ws_allowin),
        .ms_rf_zip       (ms_rf_zip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [75:0] mk_bus(input logic res, input logic sgn,
                                           input logic [3:0] mre, input logic we,
                                           input logic [4:0] waddr,
                                           input logic [31:0] alu,
                                           input logic [31:0] pc);
        return {res, sgn, mre, we, waddr, alu, pc};
    endfunction

    task automatic check(input string tag, input logic [69:0] got,
                         input logic [69:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // advance past the next rising edge; inputs change here
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // mid-cycle sampling point
    task automatic settle();
        @(negedge clk);
    endtask

    task automatic show(input string name);
        $display("%-22s t=%0t valid=%0b allowin=%0b result=0x%08h zip=0x%010h",
                 name, $time, ms2ws_valid, ms_allowin, ms2ws_bus[63:32], ms_rf_zip);
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        resetn          = 1'b0;
        es2ms_valid     = 1'b0;
        es2ms_bus       = '0;
        data_sram_rdata = 32'h0;
        ws_allowin      = 1'b1;

        // ---------------- reset state
        adv();
        adv();
        settle();
        show("reset");
        check("rst_allowin", {69'b0, ms_allowin}, 70'd1);
        check("rst_valid",   {69'b0, ms2ws_valid}, 70'd0);
        check("rst_zip",     {32'b0, ms_rf_zip}, 70'd0);
        check("rst_bus",     ms2ws_bus, 70'd0);
        resetn = 1'b1;
        adv();

        // ---------------- signed byte load, offset 3
        es2ms_valid = 1'b1;
        es2ms_bus   = mk_bus(1'b1, 1'b1, 4'h1, 1'b1, 5'd5, 32'h0000_1003, 32'h0000_0100);
        adv();
        es2ms_valid     = 1'b0;
        data_sram_rdata = 32'h8011_2233;
        settle();
        show("lb");
        check("lb_valid",  {69'b0, ms2ws_valid}, 70'd1);
        check("lb_result", {38'b0, ms2ws_bus[63:32]}, {38'b0, 32'hFFFF_FF80});
        check("lb_rfwe",   {69'b0, ms2ws_bus[69]}, 70'd1);
        check("lb_waddr",  {65'b0, ms2ws_bus[68:64]}, 70'd5);
        check("lb_pc",     {38'b0, ms2ws_bus[31:0]}, {38'b0, 32'h0000_0100});
        adv();

        // ---------------- unsigned half load, upper half
        es2ms_valid = 1'b1;
        es2ms_bus   = mk_bus(1'b1, 1'b0, 4'h3, 1'b1, 5'd6, 32'h0000_2002, 32'h0000_0104);
        adv();
        es2ms_valid     = 1'b0;
        data_sram_rdata = 32'h8001_7FFF;
        settle();
        show("lhu");
        check("lhu_result", {38'b0, ms2ws_bus[63:32]}, {38'b0, 32'h0000_8001});
        adv();

        // ---------------- signed half load, same address/data
        es2ms_valid = 1'b1;
        es2ms_bus   = mk_bus(1'b1, 1'b1, 4'h3, 1'b1, 5'd6, 32'h0000_2002, 32'h0000_0108);
        adv();
        es2ms_valid     = 1'b0;
        data_sram_rdata = 32'h8001_7FFF;
        settle();
        show("lh");
        check("lh_result", {38'b0, ms2ws_bus[63:32]}, {38'b0, 32'hFFFF_8001});
        adv();

        // ---------------- stalled word load; an ALU op waits behind it
        es2ms_valid = 1'b1;
        es2ms_bus   = mk_bus(1'b1, 1'b0, 4'hf, 1'b1, 5'd7, 32'h0000_3000, 32'h0000_010C);
        adv();
        es2ms_bus       = mk_bus(1'b0, 1'b0, 4'h0, 1'b1, 5'd8, 32'h0000_0055, 32'h0000_0110);
        data_sram_rdata = 32'h1234_5678;
        ws_allowin      = 1'b0;
        settle();
        show("lw stall 1");
        check("stall1_result",  {38'b0, ms2ws_bus[63:32]}, {38'b0, 32'h1234_5678});
        check("stall1_allowin", {69'b0, ms_allowin}, 70'd0);
        check("stall1_valid",   {69'b0, ms2ws_valid}, 70'd1);
        adv();
        data_sram_rdata = 32'hDEAD_BEEF;
        for (int i = 2; i <= 3; i++) begin
            settle();
            show("lw stall n");
            check("stall_result", {38'b0, ms2ws_bus[63:32]}, {38'b0, 32'h1234_5678});
            check("stall_zip",    {32'b0, ms_rf_zip}, {32'b0, 1'b1, 5'd7, 32'h1234_5678});
            check("stall_allowin", {69'b0, ms_allowin}, 70'd0);
            adv();
        end
        ws_allowin = 1'b1;
        settle();
        show("lw release");
        check("rel_valid",   {69'b0, ms2ws_valid}, 70'd1);
        check("rel_result",  {38'b0, ms2ws_bus[63:32]}, {38'b0, 32'h1234_5678});
        check("rel_allowin", {69'b0, ms_allowin}, 70'd1);
        adv();
        es2ms_valid = 1'b0;
        settle();
        show("after release");
        check("next_valid",  {69'b0, ms2ws_valid}, 70'd1);
        check("next_result", {38'b0, ms2ws_bus[63:32]}, {38'b0, 32'h0000_0055});
        check("next_waddr",  {65'b0, ms2ws_bus[68:64]}, 70'd8);
        adv();
        settle();
        check("drain_valid", {69'b0, ms2ws_valid}, 70'd0);
        adv();

        // ---------------- back-to-back ALU ops then a bubble
        es2ms_valid = 1'b1;
        es2ms_bus   = mk_bus(1'b0, 1'b0, 4'h0, 1'b1, 5'd10, 32'h0000_000A, 32'h0000_0200);
        adv();
        es2ms_bus   = mk_bus(1'b0, 1'b0, 4'h0, 1'b1, 5'd11, 32'h0000_000B, 32'h0000_0204);
        settle();
        show("alu A");
        check("b2b_a_valid",  {69'b0, ms2ws_valid}, 70'd1);
        check("b2b_a_result", {38'b0, ms2ws_bus[63:32]}, 70'hA);
        adv();
        es2ms_bus   = mk_bus(1'b0, 1'b0, 4'h0, 1'b1, 5'd12, 32'h0000_000C, 32'h0000_0208);
        settle();
        show("alu B");
        check("b2b_b_valid",  {69'b0, ms2ws_valid}, 70'd1);
        check("b2b_b_result", {38'b0, ms2ws_bus[63:32]}, 70'hB);
        adv();
        es2ms_valid = 1'b0;
        settle();
        show("alu C");
        check("b2b_c_valid",  {69'b0, ms2ws_valid}, 70'd1);
        check("b2b_c_result", {38'b0, ms2ws_bus[63:32]}, 70'hC);
        check("b2b_c_zipwe",  {69'b0, ms_rf_zip[37]}, 70'd1);
        adv();
        settle();
        show("bubble");
        check("bub_valid",  {69'b0, ms2ws_valid}, 70'd0);
        check("bub_zipwe",  {69'b0, ms_rf_zip[37]}, 70'd0);
        check("bub_retain", ms2ws_bus, {1'b1, 5'd12, 32'h0000_000C, 32'h0000_0208});
        adv();

        // ---------------- reset while a load is held
        es2ms_valid = 1'b1;
        es2ms_bus   = mk_bus(1'b1, 1'b0, 4'hf, 1'b1, 5'd9, 32'h0000_4000, 32'h0000_0300);
        adv();
        es2ms_valid     = 1'b0;
        data_sram_rdata = 32'hCAFE_F00D;
        ws_allowin      = 1'b0;
        adv();
        data_sram_rdata = 32'h0BAD_0BAD;
        settle();
        show("held load");
        check("held_zip", {32'b0, ms_rf_zip}, {32'b0, 1'b1, 5'd9, 32'hCAFE_F00D});
        resetn = 1'b0;
        adv();
        resetn = 1'b1;
        settle();
        show("after reset");
        check("mrst_allowin", {69'b0, ms_allowin}, 70'd1);
        check("mrst_valid",   {69'b0, ms2ws_valid}, 70'd0);
        check("mrst_zip",     {32'b0, ms_rf_zip}, 70'd0);
        check("mrst_hold",    {69'b0, dut.hold_valid_q}, 70'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
